// File: rtl/tdot_drain_if.sv
// ---------------------------------------------------------------------------
// tdot_drain_if
// Bundles the signals between the drain stage and its neighbours: the issue
// handshake and dot-unit enable, the dot unit's five lane outputs, the
// 8-bit result stream, and read-only debug views of the drain's state.
//
// Modports
//   master : the drain stage (drives issue_ready, tdot_en, out_*, dbg_*)
//   slave  : the surroundings (issuer, dot unit, stream consumer)
//
// Handshake semantics (both directions): a transfer happens on a rising
// clock edge where valid and ready are both high. The stream holds out_data,
// out_lane and out_last stable while out_valid is high and out_ready is low.
// The issue side uses issue_ready (== tdot_en) as its ready.
// ---------------------------------------------------------------------------
interface tdot_drain_if #(
  parameter int W     = 8,
  parameter int LAT   = 5,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          issue_valid;
  logic          issue_ready;
  logic          tdot_en;
  logic [W-1:0]  res_v;
  logic [W-1:0]  res_w;
  logic [W-1:0]  res_x;
  logic [W-1:0]  res_y;
  logic [W-1:0]  res_z;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    out_lane;
  logic          out_last;
  logic [CW-1:0] dbg_count;
  logic [LAT-1:0] dbg_vld;

  modport master (
    input  issue_valid, res_v, res_w, res_x, res_y, res_z, out_ready,
    output issue_ready, tdot_en, out_valid, out_data, out_lane, out_last,
           dbg_count, dbg_vld
  );

  modport slave (
    output issue_valid, res_v, res_w, res_x, res_y, res_z, out_ready,
    input  issue_ready, tdot_en, out_valid, out_data, out_lane, out_last,
           dbg_count, dbg_vld
  );
endinterface

// File: rtl/tdot_drain.sv
// ---------------------------------------------------------------------------
// tdot_drain
// Result drain for the 5-lane tensor-dot unit. A LAT-deep valid tracker
// follows issued operand sets through the dot unit; when a real result
// reaches the unit's outputs it is captured as one 5-lane entry in a
// DEPTH-entry FIFO, then serialized lane by lane (v,w,x,y,z = 0..4) onto a
// W-bit valid/ready stream. When a real result arrives while the FIFO is full
// the dot unit is frozen via tdot_en instead of losing the result.
//
// Ports
//   clock        : rising-edge clock
//   reset        : asynchronous active-low reset
//   bus (master) : issue handshake, dot-unit enable, lane inputs, output
//                  stream, debug views (dbg_count = FIFO occupancy,
//                  dbg_vld = valid tracker)
//
// LAT must be at least 2; DEPTH must be at least 2.
// ---------------------------------------------------------------------------
module tdot_drain #(
  parameter int W     = 8,
  parameter int LAT   = 5,
  parameter int DEPTH = 4
) (
  input logic          clock,
  input logic          reset,
  tdot_drain_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [2:0]    LAST_LANE = 3'd4;

  logic [LAT-1:0] r_vld;
  logic [5*W-1:0] r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic [2:0]     r_lane;

  logic           w_full;
  logic           w_empty;
  logic           w_en;
  logic           w_push;
  logic           w_beat;
  logic           w_pop;
  logic [5*W-1:0] w_head;
  logic [W-1:0]   w_lane_data;

  // full/empty come from the registered count only, so a pop on the same
  // edge never lets a push through while full.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Only a real result facing a full FIFO stalls the pipe; bubbles keep
  // flowing so later valid tokens can advance toward the outputs.
  assign w_en   = ~(r_vld[LAT-1] & w_full);
  assign w_push = r_vld[LAT-1] & ~w_full;
  assign w_beat = ~w_empty & bus.out_ready;
  assign w_pop  = w_beat & (r_lane == LAST_LANE);

  // Valid tracker mirrors the dot unit's pipeline: it advances exactly when
  // the dot unit does, so r_vld[LAT-1] lines up with res_v..res_z.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
    end else if (w_en) begin
      r_vld <= {r_vld[LAT-2:0], bus.issue_valid & w_en};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_lane  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_beat) begin
        r_lane <= (r_lane == LAST_LANE) ? 3'd0 : r_lane + 3'd1;
      end
    end
  end

  // Storage needs no reset: entries are only read when count says so.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.res_z, bus.res_y, bus.res_x, bus.res_w, bus.res_v};
    end
  end

  assign w_head = r_mem[r_rptr];

  // Empty head reads as zero so the stream is quiet after reset.
  always_comb begin
    w_lane_data = '0;
    if (!w_empty) begin
      case (r_lane)
        3'd0:    w_lane_data = w_head[0*W +: W];
        3'd1:    w_lane_data = w_head[1*W +: W];
        3'd2:    w_lane_data = w_head[2*W +: W];
        3'd3:    w_lane_data = w_head[3*W +: W];
        3'd4:    w_lane_data = w_head[4*W +: W];
        default: w_lane_data = '0;
      endcase
    end
  end

  assign bus.tdot_en     = w_en;
  assign bus.issue_ready = w_en;
  assign bus.out_valid   = ~w_empty;
  assign bus.out_data    = w_lane_data;
  assign bus.out_lane    = r_lane;
  assign bus.out_last    = (r_lane == LAST_LANE);
  assign bus.dbg_count   = r_count;
  assign bus.dbg_vld     = r_vld;
endmodule
